mem_bus_arbiter: RTL and testbench

//  Shares one 32-bit single-port memory bus between instruction fetch (IF) and the MEM-stage load/store port.

---
 rtl/mem_bus_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory bus between instruction fetch
// (IF) and the MEM-stage load/store port. One transaction runs at a time. Each
// grant ends in a single DONE cycle that carries the requester's ack and data.
// A WAIT that gets no bus_ack_i for TIMEOUT cycles is aborted with bus_err_o.
module mem_bus_arbiter #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [DATA_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_ack_o,
    input  logic                mem_ce_i,
    input  logic                mem_we_i,
    input  logic [DATA_W-1:0]   mem_addr_i,
    input  logic [DATA_W/8-1:0] mem_sel_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_ack_o,
    output logic                bus_cyc_o,
    output logic                bus_we_o,
    output logic [DATA_W-1:0]   bus_addr_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    input  logic                bus_ack_i,
    output logic                stallreq_o,
    output logic                bus_err_o
);

    localparam int             SEL_W       = DATA_W / 8;
    localparam logic [7:0]     TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        IF_WAIT  = 2'd2,
        DONE     = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    // Registered state and outputs
    state_t              r_state;
    grant_t              r_last_grant;
    logic [7:0]          r_cnt;
    logic                r_bus_cyc;
    logic                r_bus_we;
    logic [DATA_W-1:0]   r_bus_addr;
    logic [SEL_W-1:0]    r_bus_sel;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic [DATA_W-1:0]   r_if_rdata;
    logic                r_if_ack;
    logic [DATA_W-1:0]   r_mem_rdata;
    logic                r_mem_ack;
    logic                r_bus_err;

    // Next-state values
    state_t              w_state_next;
    grant_t              w_last_grant_next;
    logic [7:0]          w_cnt_next;
    logic                w_bus_cyc_next;
    logic                w_bus_we_next;
    logic [DATA_W-1:0]   w_bus_addr_next;
    logic [SEL_W-1:0]    w_bus_sel_next;
    logic [DATA_W-1:0]   w_bus_wdata_next;
    logic [DATA_W-1:0]   w_if_rdata_next;
    logic                w_if_ack_next;
    logic [DATA_W-1:0]   w_mem_rdata_next;
    logic                w_mem_ack_next;
    logic                w_bus_err_next;

    // MEM wins in IDLE when it is the only requester or when IF was served last
    logic                w_grant_mem;
    logic [7:0]          w_cnt_inc;
    logic                w_wait_end;

    assign w_grant_mem = mem_ce_i & (~if_req_i | (r_last_grant == GRANT_IF));
    assign w_cnt_inc   = r_cnt + 8'd1;
    assign w_wait_end  = bus_ack_i | (w_cnt_inc == TIMEOUT_CNT);

    // Next-state and next-output logic for the arbitration FSM
    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_cnt_next        = r_cnt;
        w_bus_cyc_next    = r_bus_cyc;
        w_bus_we_next     = r_bus_we;
        w_bus_addr_next   = r_bus_addr;
        w_bus_sel_next    = r_bus_sel;
        w_bus_wdata_next  = r_bus_wdata;
        w_if_rdata_next   = '0;
        w_if_ack_next     = 1'b0;
        w_mem_rdata_next  = '0;
        w_mem_ack_next    = 1'b0;
        w_bus_err_next    = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_grant_mem) begin
                    w_state_next      = MEM_WAIT;
                    w_last_grant_next = GRANT_MEM;
                    w_cnt_next        = '0;
                    w_bus_cyc_next    = 1'b1;
                    w_bus_we_next     = mem_we_i;
                    w_bus_addr_next   = mem_addr_i;
                    w_bus_sel_next    = mem_sel_i;
                    w_bus_wdata_next  = mem_wdata_i;
                end else if (if_req_i) begin
                    w_state_next      = IF_WAIT;
                    w_last_grant_next = GRANT_IF;
                    w_cnt_next        = '0;
                    w_bus_cyc_next    = 1'b1;
                    w_bus_we_next     = 1'b0;
                    w_bus_addr_next   = if_addr_i;
                    w_bus_sel_next    = '1;
                    w_bus_wdata_next  = '0;
                end
            end

            MEM_WAIT, IF_WAIT: begin
                if (w_wait_end) begin
                    // A real ack wins over a timeout landing on the same cycle
                    w_state_next     = DONE;
                    w_cnt_next       = '0;
                    w_bus_cyc_next   = 1'b0;
                    w_bus_we_next    = 1'b0;
                    w_bus_addr_next  = '0;
                    w_bus_sel_next   = '0;
                    w_bus_wdata_next = '0;
                    w_bus_err_next   = ~bus_ack_i;
                    if (r_state == MEM_WAIT) begin
                        w_mem_ack_next   = 1'b1;
                        w_mem_rdata_next = bus_ack_i ? bus_rdata_i : '0;
                    end else begin
                        w_if_ack_next    = 1'b1;
                        w_if_rdata_next  = bus_ack_i ? bus_rdata_i : '0;
                    end
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end

            DONE: begin
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_IF;
            r_cnt        <= '0;
            r_bus_cyc    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_sel    <= '0;
            r_bus_wdata  <= '0;
            r_if_rdata   <= '0;
            r_if_ack     <= 1'b0;
            r_mem_rdata  <= '0;
            r_mem_ack    <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
            r_cnt        <= w_cnt_next;
            r_bus_cyc    <= w_bus_cyc_next;
            r_bus_we     <= w_bus_we_next;
            r_bus_addr   <= w_bus_addr_next;
            r_bus_sel    <= w_bus_sel_next;
            r_bus_wdata  <= w_bus_wdata_next;
            r_if_rdata   <= w_if_rdata_next;
            r_if_ack     <= w_if_ack_next;
            r_mem_rdata  <= w_mem_rdata_next;
            r_mem_ack    <= w_mem_ack_next;
            r_bus_err    <= w_bus_err_next;
        end
    end

    assign bus_cyc_o   = r_bus_cyc;
    assign bus_we_o    = r_bus_we;
    assign bus_addr_o  = r_bus_addr;
    assign bus_sel_o   = r_bus_sel;
    assign bus_wdata_o = r_bus_wdata;
    assign if_rdata_o  = r_if_rdata;
    assign if_ack_o    = r_if_ack;
    assign mem_rdata_o = r_mem_rdata;
    assign mem_ack_o   = r_mem_ack;
    assign bus_err_o   = r_bus_err;

    // Stall drops in the ack cycle so the pipeline advances on that edge
    assign stallreq_o = (mem_ce_i & ~r_mem_ack) | (if_req_i & ~r_if_ack);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench. The expected transaction is queued
// when a request is driven. A bus responder acks each transaction after its
// programmed delay. A monitor checks the bus fields on every WAIT cycle. It
// pops and compares the queue entry on each ack pulse.
module tb_mem_bus_arbiter;

    localparam int TIMEOUT = 15;
    localparam int NEVER   = 255;

    typedef struct {
        bit          is_mem;
        logic [31:0] addr;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          delay;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        bus_cyc_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        stallreq_o;
    logic        bus_err_o;

    logic        spur_ack;
    exp_t        exp_q[$];
    int          n_checks;
    int          n_fails;

    mem_bus_arbiter #(.DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ack_o    (if_ack_o),
        .mem_ce_i    (mem_ce_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_sel_i   (mem_sel_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_ack_o   (mem_ack_o),
        .bus_cyc_o   (bus_cyc_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_sel_o   (bus_sel_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rdata_i (bus_rdata_i),
        .bus_ack_i   (bus_ack_i),
        .stallreq_o  (stallreq_o),
        .bus_err_o   (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_checks = 0;
        n_fails  = 0;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Expected bus image and result of one granted transaction
    function automatic exp_t make_exp(input bit is_mem, input bit we, input logic [31:0] addr,
                                      input logic [3:0] sel, input logic [31:0] wdata,
                                      input logic [31:0] rdata, input int delay);
        exp_t e;
        e.is_mem = is_mem;
        e.addr   = addr;
        e.we     = is_mem ? we : 1'b0;
        e.sel    = is_mem ? sel : 4'hF;
        e.wdata  = is_mem ? wdata : 32'h0;
        e.err    = (delay >= TIMEOUT);
        e.rdata  = e.err ? 32'h0 : rdata;
        e.delay  = delay;
        e.lat    = e.err ? TIMEOUT : delay + 1;
        return e;
    endfunction

    // Bus responder: acks the head transaction after its delay, else idles
    initial begin
        int w;
        w           = 0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_cyc_o && exp_q.size() > 0) begin
                bus_ack_i   = (w == exp_q[0].delay);
                bus_rdata_i = bus_ack_i ? exp_q[0].rdata : (32'hBAD0_0000 + 32'(w));
                w++;
            end else begin
                w           = 0;
                bus_ack_i   = spur_ack;
                bus_rdata_i = 32'hFFFF_FFFF;
            end
        end
    end

    // Monitor: bus fields on every WAIT cycle, results on every ack pulse
    initial begin
        bit   prev_cyc;
        int   cyc_n;
        exp_t e;
        prev_cyc = 1'b0;
        cyc_n    = 0;
        forever begin
            @(negedge clk);
            if (bus_cyc_o) begin
                if (!prev_cyc) cyc_n = 0;
                cyc_n++;
                if (exp_q.size() == 0) begin
                    check("bus_cyc_unexpected", bus_cyc_o, 1'b0);
                end else begin
                    check("bus_addr", bus_addr_o, exp_q[0].addr);
                    check("bus_we", bus_we_o, exp_q[0].we);
                    check("bus_sel", bus_sel_o, exp_q[0].sel);
                    check("bus_wdata", bus_wdata_o, exp_q[0].wdata);
                end
            end
            if (mem_ack_o || if_ack_o) begin
                if (exp_q.size() == 0) begin
                    check("ack_spurious", {mem_ack_o, if_ack_o}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check("mem_ack", mem_ack_o, e.is_mem);
                    check("if_ack", if_ack_o, !e.is_mem);
                    check("rdata", e.is_mem ? mem_rdata_o : if_rdata_o, e.rdata);
                    check("rdata_other", e.is_mem ? if_rdata_o : mem_rdata_o, 32'h0);
                    check("bus_err", bus_err_o, e.err);
                    check("latency", cyc_n, e.lat);
                    check("cyc_in_done", bus_cyc_o, 1'b0);
                end
            end else if (bus_err_o) begin
                check("bus_err_stray", bus_err_o, 1'b0);
            end
            prev_cyc = bus_cyc_o;
        end
    end

    // One request from a single requester; flush_at > 0 drops it mid-WAIT
    task automatic txn(input bit is_mem, input bit we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int delay, input int flush_at);
        int n;
        bit seen;
        exp_q.push_back(make_exp(is_mem, we, addr, sel, wdata, rdata, delay));
        @(posedge clk);
        #1;
        // NOTE: bench drives inputs with blocking assignments, away from the sampling edge
        if (is_mem) begin
            mem_ce_i    = 1'b1;
            mem_we_i    = we;
            mem_addr_i  = addr;
            mem_sel_i   = sel;
            mem_wdata_i = wdata;
        end else begin
            if_req_i  = 1'b1;
            if_addr_i = addr;
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (n == flush_at) begin
                if_req_i    = 1'b0;
                mem_ce_i    = 1'b0;
                if_addr_i   = ~addr;
                mem_addr_i  = ~addr;
                mem_wdata_i = ~wdata;
            end
            seen = mem_ack_o | if_ack_o;
        end
        check("ack_seen", seen, 1'b1);
        if_req_i = 1'b0;
        mem_ce_i = 1'b0;
        if (!seen) exp_q.delete();
    endtask

    initial begin
        int n;
        int acks;

        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int acks;

        rst         = 1'b0;
        spur_ack    = 1'b0;
        mem_ce_i    = 1'b1;
        mem_we_i    = 1'b0;
        mem_addr_i  = 32'h300;
        mem_sel_i   = 4'b1010;
        mem_wdata_i = 32'h1234_5678;
        if_req_i    = 1'b1;
        if_addr_i   = 32'h0;

        // Reset held with both requests active: everything registered is 0
        repeat (3) @(negedge clk);
        check("rst_bus_cyc", bus_cyc_o, 1'b0);
        check("rst_bus_we", bus_we_o, 1'b0);
        check("rst_bus_addr", bus_addr_o, 32'h0);
        check("rst_bus_sel", bus_sel_o, 4'h0);
        check("rst_bus_wdata", bus_wdata_o, 32'h0);
        check("rst_if_ack", if_ack_o, 1'b0);
        check("rst_mem_ack", mem_ack_o, 1'b0);
        check("rst_if_rdata", if_rdata_o, 32'h0);
        check("rst_mem_rdata", mem_rdata_o, 32'h0);
        check("rst_bus_err", bus_err_o, 1'b0);
        check("rst_stall", stallreq_o, 1'b1);

        // Release with no requests: no spurious activity
        mem_ce_i = 1'b0;
        if_req_i = 1'b0;
        #2 rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_no_ack", {mem_ack_o, if_ack_o}, 2'b00);
            check("post_rst_idle", bus_cyc_o, 1'b0);
        end

        // Contention from reset: MEM, IF, MEM, IF
        #2 rst = 1'b0;
        mem_ce_i = 1'b1;
        if_req_i = 1'b1;
        exp_q.push_back(make_exp(1'b1, 1'b0, 32'h300, 4'b1010, 32'h1234_5678, 32'hA000_0001, 0));
        exp_q.push_back(make_exp(1'b0, 1'b0, 32'h0,   4'hF,    32'h0,        32'hB000_0002, 1));
        exp_q.push_back(make_exp(1'b1, 1'b0, 32'h300, 4'b1010, 32'h1234_5678, 32'hA000_0003, 2));
        exp_q.push_back(make_exp(1'b0, 1'b0, 32'h0,   4'hF,    32'h0,        32'hB000_0004, 0));
        @(negedge clk);
        #2 rst = 1'b1;
        n    = 0;
        acks = 0;
        while (acks < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (mem_ack_o) check("cont_stall_if_pending", stallreq_o, 1'b1);
            if (mem_ack_o || if_ack_o) acks++;
        end
        mem_ce_i = 1'b0;
        if_req_i = 1'b0;
        check("cont_acks", acks, 4);

        // Minimum-latency MEM load, cycle by cycle
        exp_q.push_back(make_exp(1'b1, 1'b0, 32'h100, 4'b0100, 32'hDEAD_BEEF, 32'h1122_3344, 0));
        @(posedge clk);
        #1;
        mem_ce_i    = 1'b1;
        mem_we_i    = 1'b0;
        mem_addr_i  = 32'h100;
        mem_sel_i   = 4'b0100;
        mem_wdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        check("ld_c0_stall", stallreq_o, 1'b1);
        check("ld_c0_cyc", bus_cyc_o, 1'b0);
        @(negedge clk);
        check("ld_c1_cyc", bus_cyc_o, 1'b1);
        check("ld_c1_stall", stallreq_o, 1'b1);
        @(negedge clk);
        check("ld_c2_ack", mem_ack_o, 1'b1);
        check("ld_c2_rdata", mem_rdata_o, 32'h1122_3344);
        check("ld_c2_stall", stallreq_o, 1'b0);
        @(posedge clk);
        #1 mem_ce_i = 1'b0;
        @(negedge clk);
        check("ld_c3_ack", mem_ack_o, 1'b0);
        check("ld_c3_rdata", mem_rdata_o, 32'h0);
        check("ld_c3_cyc", bus_cyc_o, 1'b0);

        // Store with ack delayed 5 cycles
        txn(1'b1, 1'b1, 32'h204, 4'b0011, 32'hAABB_CCDD, 32'h0, 5, 0);

        // Timeout abort, then back to IDLE
        txn(1'b1, 1'b0, 32'h208, 4'hF, 32'h0, 32'h55AA_55AA, NEVER, 0);
        @(negedge clk);
        check("to_idle_cyc", bus_cyc_o, 1'b0);
        check("to_err_one_cycle", bus_err_o, 1'b0);

        // Ack on the last allowed WAIT cycle still completes normally
        txn(1'b0, 1'b0, 32'h80, 4'hF, 32'h0, 32'hCAFE_F00D, TIMEOUT - 1, 0);

        // IF flushed mid-WAIT: transaction completes, input changes ignored
        txn(1'b0, 1'b0, 32'h1000, 4'hF, 32'h0, 32'h0BAD_F00D, 3, 2);

        // bus_ack_i in IDLE and DONE is ignored
        spur_ack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("spur_idle_cyc", bus_cyc_o, 1'b0);
            check("spur_idle_ack", {mem_ack_o, if_ack_o}, 2'b00);
        end
        txn(1'b0, 1'b0, 32'h2000, 4'hF, 32'h0, 32'h1357_9BDF, 2, 0);
        spur_ack = 1'b0;

        // Misaligned sel/addr passes through unchanged
        txn(1'b1, 1'b1, 32'h103, 4'b0110, 32'h0F0F_0F0F, 32'h0, 0, 0);

        // Reset mid-IF_WAIT: cycle drops at once, no ack, next request normal
        exp_q.push_back(make_exp(1'b0, 1'b0, 32'h40, 4'hF, 32'h0, 32'h0, NEVER));
        @(posedge clk);
        #1;
        if_req_i  = 1'b1;
        if_addr_i = 32'h40;
        n = 0;
        while (!bus_cyc_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rw_granted", bus_cyc_o, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rw_cyc_async", bus_cyc_o, 1'b0);
        check("rw_addr_async", bus_addr_o, 32'h0);
        check("rw_if_ack", if_ack_o, 1'b0);
        exp_q.delete();
        if_req_i = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rw_no_ack", if_ack_o, 1'b0);
        end
        txn(1'b0, 1'b0, 32'h44, 4'hF, 32'h0, 32'h2468_ACE0, 1, 0);

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
